// File: rtl/alu_result_uart_tx.sv
// ALU result buffer and UART-style serialiser: FIFO of 8-bit results shifted out
// as start / 8 data LSB-first / [even parity] / stop. Optional macro: RESULT_PARITY_EN.
module alu_result_uart_tx #(
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 res_in,
  input  logic                       res_valid,
  output logic                       res_ready,
  input  logic                       ovf_clr,
  output logic                       tx,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          full;
  logic          push;
  logic          pop;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_idx_n;
  logic [7:0]    shreg;
  logic [7:0]    shreg_n;
  logic          par;
  logic          par_n;
  logic          tx_n;

  assign full      = (level == LVL_FULL);
  assign res_ready = !full;
  assign push      = res_valid && !full;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= res_in;
    end
  end

  // FIFO pointers, occupancy and sticky overflow; a drop beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= {PW{1'b0}};
      rptr     <= {PW{1'b0}};
      level    <= {LW{1'b0}};
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + PW'(1'b1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1'b1);
      end
      level <= level + LW'(push) - LW'(pop);
      if (res_valid && full) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= {CW{1'b0}};
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
      par     <= 1'b0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      par     <= par_n;
      tx      <= tx_n;
    end
  end

  // Next state; tx is computed from the state being entered so it lines up with it
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    par_n     = par;
    pop       = 1'b0;
    tx_n      = 1'b1;
    case (state)
      IDLE: begin
        if (level != {LW{1'b0}}) begin
          pop     = 1'b1;
          shreg_n = mem[rptr];
          par_n   = ^mem[rptr];
          cnt_n   = {CW{1'b0}};
          state_n = START;
        end
      end
      START: begin
        if (cnt == CNT_LAST) begin
          cnt_n     = {CW{1'b0}};
          bit_idx_n = 3'd0;
          state_n   = DATA;
        end else begin
          cnt_n = cnt + CW'(1'b1);
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n = {CW{1'b0}};
          if (bit_idx == 3'd7) begin
`ifdef RESULT_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            shreg_n   = {1'b0, shreg[7:1]};
          end
        end else begin
          cnt_n = cnt + CW'(1'b1);
        end
      end
`ifdef RESULT_PARITY_EN
      PARITY: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = {CW{1'b0}};
          state_n = STOP;
        end else begin
          cnt_n = cnt + CW'(1'b1);
        end
      end
`endif
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = {CW{1'b0}};
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CW'(1'b1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    case (state_n)
      IDLE:    tx_n = 1'b1;
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
`ifdef RESULT_PARITY_EN
      PARITY:  tx_n = par_n;
`endif
      STOP:    tx_n = 1'b1;
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_alu_result_uart_tx.sv
// Bench for alu_result_uart_tx: a queue/waveform model checked every cycle,
// plus hand-computed literal checks of the framing.
module tb_alu_result_uart_tx;

  localparam int DEPTH = 4;
  localparam int CPB   = 4;
`ifdef RESULT_PARITY_EN
  localparam int FRAME_LEN = 11 * CPB;
`else
  localparam int FRAME_LEN = 10 * CPB;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] res_in = 8'd0;
  logic       res_valid = 1'b0;
  logic       res_ready;
  logic       ovf_clr = 1'b0;
  logic       tx;
  logic       busy;
  logic [2:0] level;
  logic       overflow;

  logic [7:0] res1 = 8'd0;
  logic       valid1 = 1'b0;
  logic       ready1;
  logic       tx1;
  logic       busy1;
  logic [2:0] level1;
  logic       ovf1;

  int total = 0;
  int bad   = 0;

  alu_result_uart_tx #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .res_in(res_in), .res_valid(res_valid), .res_ready(res_ready),
    .ovf_clr(ovf_clr), .tx(tx), .busy(busy), .level(level), .overflow(overflow)
  );

  alu_result_uart_tx #(.DEPTH(DEPTH), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .res_in(res1), .res_valid(valid1), .res_ready(ready1),
    .ovf_clr(1'b0), .tx(tx1), .busy(busy1), .level(level1), .overflow(ovf1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: FIFO as a queue, each frame as a queue of per-cycle tx values
  logic [7:0] fq[$];
  logic       wave[$];
  logic       m_tx = 1'b1;
  logic       m_busy = 1'b0;
  logic       m_ovf = 1'b0;
  int         m_pre;
  logic [7:0] m_byte;

  always @(posedge clk) begin
    if (rst) begin
      fq.delete();
      wave.delete();
      m_tx = 1'b1;
      m_busy = 1'b0;
      m_ovf = 1'b0;
    end else begin
      m_pre = fq.size();
      if (wave.size() > 0) begin
        m_tx = wave.pop_front();
        m_busy = 1'b1;
      end else if (m_busy) begin
        m_tx = 1'b1;
        m_busy = 1'b0;
      end else if (m_pre > 0) begin
        m_byte = fq.pop_front();
        for (int i = 0; i < CPB; i++) wave.push_back(1'b0);
        for (int b = 0; b < 8; b++)
          for (int i = 0; i < CPB; i++) wave.push_back(m_byte[b]);
`ifdef RESULT_PARITY_EN
        for (int i = 0; i < CPB; i++) wave.push_back(^m_byte);
`endif
        for (int i = 0; i < CPB; i++) wave.push_back(1'b1);
        m_tx = wave.pop_front();
        m_busy = 1'b1;
      end else begin
        m_tx = 1'b1;
        m_busy = 1'b0;
      end
      if (res_valid && m_pre < DEPTH) fq.push_back(res_in);
      if (res_valid && m_pre == DEPTH) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
    end
    #1;
    chk("model_tx", int'(tx), int'(m_tx));
    chk("model_busy", int'(busy), int'(m_busy));
    chk("model_level", int'(level), fq.size());
    chk("model_overflow", int'(overflow), int'(m_ovf));
    chk("model_ready", int'(res_ready), int'(fq.size() < DEPTH));
  end

  logic txlog [1:60];
  logic busylog [1:60];

  task automatic send_and_log(input logic [7:0] b);
    res_in = b;
    res_valid = 1'b1;
    @(posedge clk);
    #2;
    res_valid = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #2;
      txlog[k] = tx;
      busylog[k] = busy;
    end
  endtask

`ifdef RESULT_PARITY_EN
  localparam int N6 = 24;
  logic [1:N6] exp6 = 24'b011111111011_000000000011;
`else
  localparam int N6 = 22;
  logic [1:N6] exp6 = 22'b01111111111_00000000011;
`endif

  logic [7:0] a5 = 8'hA5;
  logic       log6 [1:N6];

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("reset_tx", int'(tx), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_level", int'(level), 0);
    chk("reset_overflow", int'(overflow), 0);
    chk("reset_ready", int'(res_ready), 1);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    // single frame 0xA5
    send_and_log(8'hA5);
    for (int k = 1; k <= 4; k++) chk("a5_start", int'(txlog[k]), 0);
    for (int i = 0; i < 8; i++) chk("a5_data", int'(txlog[6 + 4 * i]), int'(a5[i]));
    chk("a5_stop", int'(txlog[FRAME_LEN]), 1);
    chk("a5_busy_last", int'(busylog[FRAME_LEN]), 1);
    chk("a5_busy_end", int'(busylog[FRAME_LEN + 1]), 0);
    chk("a5_level", int'(level), 0);

`ifdef RESULT_PARITY_EN
    send_and_log(8'h07);
    chk("p07_parity", int'(txlog[38]), 1);
    chk("p07_busy_last", int'(busylog[44]), 1);
    chk("p07_busy_end", int'(busylog[45]), 0);
`endif

    // six back-to-back pushes, sixth dropped
    for (int i = 0; i < 6; i++) begin
      res_in = 8'(i + 1);
      res_valid = 1'b1;
      @(posedge clk);
      #2;
      if (i == 4) begin
        chk("b2b_level4", int'(level), 4);
        chk("b2b_ready0", int'(res_ready), 0);
      end
    end
    res_valid = 1'b0;
    chk("b2b_overflow", int'(overflow), 1);
    chk("b2b_level_after", int'(level), 4);
    repeat (5 * (FRAME_LEN + 1) + 10) @(posedge clk);
    #2;
    chk("b2b_drained", int'(level), 0);

    // drop coinciding with clear
    ovf_clr = 1'b1;
    @(posedge clk);
    #2;
    ovf_clr = 1'b0;
    chk("clr_alone_first", int'(overflow), 0);
    for (int i = 0; i < 20; i++) begin
      if (!res_ready) break;
      res_in = 8'($urandom);
      res_valid = 1'b1;
      @(posedge clk);
      #2;
    end
    chk("fill_full", int'(res_ready), 0);
    res_valid = 1'b1;
    ovf_clr = 1'b1;
    @(posedge clk);
    #2;
    res_valid = 1'b0;
    chk("drop_and_clr", int'(overflow), 1);
    @(posedge clk);
    #2;
    ovf_clr = 1'b0;
    chk("clr_alone", int'(overflow), 0);
    repeat (5 * (FRAME_LEN + 1) + 10) @(posedge clk);
    #2;

    // reset in the middle of DATA with two entries queued
    for (int i = 0; i < 3; i++) begin
      res_in = 8'h30 + 8'(i);
      res_valid = 1'b1;
      @(posedge clk);
      #2;
    end
    res_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    chk("mid_level", int'(level), 2);
    chk("mid_busy", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    chk("rst_tx", int'(tx), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_level", int'(level), 0);
    repeat (60) @(posedge clk);
    #2;
    chk("rst_no_restart", int'(busy), 0);

    // one clock per bit, 0xFF then 0x00
    res1 = 8'hFF;
    valid1 = 1'b1;
    @(posedge clk);
    #2;
    res1 = 8'h00;
    for (int k = 1; k <= N6; k++) begin
      @(posedge clk);
      #2;
      if (k == 1) valid1 = 1'b0;
      log6[k] = tx1;
    end
    for (int k = 1; k <= N6; k++) chk("cpb1_wave", int'(log6[k]), int'(exp6[k]));
    chk("cpb1_idle", int'(busy1), 0);

    repeat (3) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
